z80_pio_bank: RTL and testbench



---
 rtl/z80_pio_bank_pkg.sv | 25 ++
 rtl/z80_pio_bank_if.sv | 16 +
 rtl/z80_pio_bank_channel.sv | 77 +++++++
 rtl/z80_pio_bank.sv | 72 +++++++
 tb/tb_z80_pio_bank.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/z80_pio_bank_pkg.sv
// Shared definitions for the Z80 parallel I/O bank: register offsets, limits, parameter check.
// Latency: n/a (no logic).
// Backpressure: n/a.
package pio_pkg;

    localparam int MAX_PORTS = 16;

    // Register offset within a port's 4-address window.
    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_DIR   = 2'd1,
        REG_IMASK = 2'd2,
        REG_ISTAT = 2'd3
    } reg_sel_e;

    // True when the bank geometry fits the 8-bit I/O space and the synchroniser depth is sane.
    function automatic bit pio_params_ok(input int num_ports, input int base_addr,
                                         input int sync_stages);
        return (num_ports >= 1) && (num_ports <= MAX_PORTS) &&
               (base_addr % 4 == 0) && (base_addr >= 0) &&
               (base_addr + 4 * num_ports - 1 <= 255) &&
               (sync_stages >= 2) && (sync_stages <= 3);
    endfunction

endpackage

// File: rtl/z80_pio_bank_if.sv
// Z80 I/O bus as seen by a peripheral: address, strobes, data both ways, select and interrupt.
// Latency: n/a (wiring only).
// Backpressure: none; the Z80 bus has no wait handshake here.
// master = CPU side (drives addr/n_wr/n_rd/dataIn), slave = peripheral side.
interface z80_pio_bank_if;
    logic [7:0] addr;
    logic       n_wr;
    logic       n_rd;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       n_cs;
    logic       n_int;

    modport master (output addr, n_wr, n_rd, dataIn, input  dataOut, n_cs, n_int);
    modport slave  (input  addr, n_wr, n_rd, dataIn, output dataOut, n_cs, n_int);
endinterface

// File: rtl/z80_pio_bank_channel.sv
// One 8-bit parallel port: DATA/DIR/IMASK/ISTAT registers, input synchroniser, rising-edge capture.
// Latency: register write lands on the strobe edge, pins follow one cycle later; input edge flags after SYNC_STAGES+1 edges.
// Backpressure: none; every write strobe is accepted.
// Ports: cpuClock, n_reset (sync, active-high); pin_in async pads; wr_en/reg_sel/wdata from the bank decoder;
//        pin_out/pin_oe registered pad controls; rdata selected register readback; irq = any unmasked flag.
module pio_channel
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       cpuClock,
    input  logic       n_reset,
    input  logic [7:0] pin_in,
    input  logic       wr_en,
    input  reg_sel_e   reg_sel,
    input  logic [7:0] wdata,
    output logic [7:0] pin_out,
    output logic [7:0] pin_oe,
    output logic [7:0] rdata,
    output logic       irq
);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] sync_d;
    logic [7:0] prev_q;
    logic [7:0] data_q, dir_q, imask_q, istat_q;
    logic [7:0] edge_set, w1c;

    assign sync_d = sync_q[SYNC_STAGES-1];

    // prev tracks sync_d on every bit regardless of direction, so flipping a
    // bit from output to input never manufactures an edge.
    assign edge_set = ~dir_q & ~prev_q & sync_d;
    assign w1c      = (wr_en && reg_sel == REG_ISTAT) ? wdata : 8'h00;

    always_ff @(posedge cpuClock) begin
        if (n_reset) begin
            sync_q  <= '0;
            prev_q  <= '0;
            data_q  <= '0;
            dir_q   <= '0;
            imask_q <= '0;
            istat_q <= '0;
            pin_out <= '0;
            pin_oe  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_in};
            prev_q  <= sync_d;
            pin_out <= data_q;
            pin_oe  <= dir_q;
            // A new edge beats a same-cycle clear on the same bit.
            istat_q <= (istat_q & ~w1c) | edge_set;
            if (wr_en) begin
                case (reg_sel)
                    REG_DATA:  data_q  <= wdata;
                    REG_DIR:   dir_q   <= wdata;
                    REG_IMASK: imask_q <= wdata;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (reg_sel)
            REG_DATA:  rdata = (data_q & dir_q) | (sync_d & ~dir_q);
            REG_DIR:   rdata = dir_q;
            REG_IMASK: rdata = imask_q;
            REG_ISTAT: rdata = istat_q;
            default:   rdata = 8'h00;
        endcase
    end

    assign irq = |(istat_q & imask_q);

endmodule

// File: rtl/z80_pio_bank.sv
// Bank of NUM_PORTS bidirectional 8-bit parallel ports on the Z80 I/O bus with maskable edge interrupt.
// Latency: reads combinational; writes take effect on the first edge of the strobe (one per strobe).
// Backpressure: none; the bank never stalls the CPU.
// Ports: cpuClock, n_reset (sync, active-high); bus (slave modport: addr, n_wr, n_rd, dataIn, dataOut, n_cs, n_int);
//        pin_in/pin_out/pin_oe, port p on bits [8p+7:8p].
module z80_pio_bank
    import pio_pkg::*;
#(
    parameter int         NUM_PORTS   = 2,
    parameter logic [7:0] BASE_ADDR   = 8'h90,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   cpuClock,
    input  logic                   n_reset,
    z80_pio_bank_if.slave          bus,
    input  logic [8*NUM_PORTS-1:0] pin_in,
    output logic [8*NUM_PORTS-1:0] pin_out,
    output logic [8*NUM_PORTS-1:0] pin_oe
);

    if (!pio_params_ok(NUM_PORTS, int'(BASE_ADDR), SYNC_STAGES)) begin : g_bad_params
        $error("z80_pio_bank: illegal NUM_PORTS/BASE_ADDR/SYNC_STAGES");
    end

    localparam int LAST_ADDR = int'(BASE_ADDR) + 4 * NUM_PORTS - 1;

    logic       hit;
    logic [3:0] port_sel;
    logic       wr_q;
    logic       wr_pulse;
    logic [7:0] rd_mux;
    logic [7:0] ch_rdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] ch_irq;

    assign hit      = (bus.addr >= BASE_ADDR) && (int'(bus.addr) <= LAST_ADDR);
    assign port_sel = 4'((bus.addr - BASE_ADDR) >> 2);

    // wr_q resets low, so a strobe already asserted when reset lifts never writes.
    always_ff @(posedge cpuClock) begin
        if (n_reset) wr_q <= 1'b0;
        else         wr_q <= bus.n_wr;
    end

    assign wr_pulse = hit && !bus.n_wr && wr_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        pio_channel #(.SYNC_STAGES(SYNC_STAGES)) u_channel (
            .cpuClock (cpuClock),
            .n_reset  (n_reset),
            .pin_in   (pin_in[8*p +: 8]),
            .wr_en    (wr_pulse && (port_sel == 4'(p))),
            .reg_sel  (reg_sel_e'(bus.addr[1:0])),
            .wdata    (bus.dataIn),
            .pin_out  (pin_out[8*p +: 8]),
            .pin_oe   (pin_oe[8*p +: 8]),
            .rdata    (ch_rdata[p]),
            .irq      (ch_irq[p])
        );
    end

    always_comb begin
        rd_mux = 8'hFF;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_sel == 4'(p)) rd_mux = ch_rdata[p];
        end
    end

    assign bus.n_cs    = !(hit && (!bus.n_rd || !bus.n_wr));
    assign bus.dataOut = bus.n_cs ? 8'hFF : rd_mux;
    assign bus.n_int   = !(|ch_irq);

endmodule

// File: tb/tb_z80_pio_bank.sv
// Self-checking bench for z80_pio_bank (2 ports at 0x90, 2 sync stages).
// Latency: n/a.
// Backpressure: n/a.
module tb_z80_pio_bank;

    logic        cpuClock = 1'b0;
    logic        n_reset;
    logic [15:0] pin_in;
    logic [15:0] pin_out, pin_oe;

    z80_pio_bank_if bus();

    z80_pio_bank #(.NUM_PORTS(2), .BASE_ADDR(8'h90), .SYNC_STAGES(2)) dut (
        .cpuClock (cpuClock),
        .n_reset  (n_reset),
        .bus      (bus),
        .pin_in   (pin_in),
        .pin_out  (pin_out),
        .pin_oe   (pin_oe)
    );

    always #5 cpuClock = ~cpuClock;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;

    always @(negedge cpuClock) if (!n_reset && dut.wr_pulse) wr_cnt++;

    // Behavioural model: register contents and last pin value seen per port.
    logic [7:0] m_data [2];
    logic [7:0] m_dir  [2];
    logic [7:0] m_imask[2];
    logic [7:0] m_istat[2];
    logic [7:0] m_last [2];

    task automatic cyc();
        @(posedge cpuClock);
        #1;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_data[p] = 0; m_dir[p] = 0; m_imask[p] = 0; m_istat[p] = 0; m_last[p] = 0;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int len);
        int p;
        bus.addr = a; bus.dataIn = d; bus.n_wr = 1'b0;
        repeat (len) cyc();
        bus.n_wr = 1'b1;
        cyc();
        if (a >= 8'h90 && a <= 8'h97) begin
            p = (int'(a) - 'h90) / 4;
            case (int'(a) % 4)
                0: m_data[p] = d;
                1: m_dir[p] = d;
                2: m_imask[p] = d;
                default: m_istat[p] = m_istat[p] & ~d;
            endcase
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic cs);
        bus.addr = a; bus.n_rd = 1'b0;
        #1;
        d = bus.dataOut; cs = bus.n_cs;
        bus.n_rd = 1'b1;
    endtask

    // Pins change: rising edges on input bits become sticky flags.
    task automatic set_pins(input logic [15:0] v);
        for (int p = 0; p < 2; p++) begin
            m_istat[p] = m_istat[p] | (v[8*p +: 8] & ~m_last[p] & ~m_dir[p]);
            m_last[p]  = v[8*p +: 8];
        end
        pin_in = v;
    endtask

    function automatic logic exp_n_int();
        return !(|(m_istat[0] & m_imask[0]) || |(m_istat[1] & m_imask[1]));
    endfunction

    task automatic test_reset();
        logic [7:0] d; logic cs;
        n_reset = 1'b1; bus.n_wr = 1'b1; bus.n_rd = 1'b1; bus.addr = 8'h00; bus.dataIn = 8'h00;
        pin_in = 16'h0000;
        model_reset();
        repeat (2) cyc();
        n_reset = 1'b0;
        cyc();
        n_cmp++; if (pin_out !== 16'h0000) begin n_err++; $display("FAIL reset_pin_out got %h want 0000", pin_out); end
        n_cmp++; if (pin_oe !== 16'h0000) begin n_err++; $display("FAIL reset_pin_oe got %h want 0000", pin_oe); end
        n_cmp++; if (bus.n_int !== 1'b1) begin n_err++; $display("FAIL reset_n_int got %b want 1", bus.n_int); end
        for (int a = 'h90; a <= 'h97; a++) begin
            rd(8'(a), d, cs);
            n_cmp++; if (d !== 8'h00 || cs !== 1'b0) begin n_err++; $display("FAIL reset_read_%h got %h cs=%b want 00 cs=0", a, d, cs); end
            cyc();
        end
        rd(8'h98, d, cs);
        n_cmp++; if (d !== 8'hFF || cs !== 1'b1) begin n_err++; $display("FAIL read_outside got %h cs=%b want FF cs=1", d, cs); end
        bus.addr = 8'h90; #1;
        n_cmp++; if (bus.dataOut !== 8'hFF || bus.n_cs !== 1'b1) begin n_err++; $display("FAIL idle_hit got %h cs=%b want FF cs=1", bus.dataOut, bus.n_cs); end
    endtask

    task automatic test_long_strobe();
        int c0;
        logic [7:0] d; logic cs;
        c0 = wr_cnt;
        bus.addr = 8'h91; bus.dataIn = 8'hFF; bus.n_wr = 1'b0;
        #1;
        n_cmp++; if (bus.n_cs !== 1'b0) begin n_err++; $display("FAIL write_n_cs got %b want 0", bus.n_cs); end
        cyc();
        n_cmp++; if (pin_oe[7:0] !== 8'h00) begin n_err++; $display("FAIL pin_oe_edge1 got %h want 00", pin_oe[7:0]); end
        cyc();
        n_cmp++; if (pin_oe[7:0] !== 8'hFF) begin n_err++; $display("FAIL pin_oe_edge2 got %h want FF", pin_oe[7:0]); end
        repeat (3) cyc();
        bus.n_wr = 1'b1;
        cyc();
        m_dir[0] = 8'hFF;
        n_cmp++; if (wr_cnt - c0 !== 1) begin n_err++; $display("FAIL long_strobe_count got %0d want 1", wr_cnt - c0); end
        c0 = wr_cnt;
        wr(8'h90, 8'hA5, 4);
        n_cmp++; if (pin_out[7:0] !== 8'hA5) begin n_err++; $display("FAIL pin_out_a5 got %h want A5", pin_out[7:0]); end
        n_cmp++; if (wr_cnt - c0 !== 1) begin n_err++; $display("FAIL data_strobe_count got %0d want 1", wr_cnt - c0); end
        rd(8'h91, d, cs);
        n_cmp++; if (d !== 8'hFF) begin n_err++; $display("FAIL dir_readback got %h want FF", d); end
    endtask

    task automatic test_mixed_readback();
        logic [7:0] d; logic cs;
        wr(8'h91, 8'h0F, 1);
        pin_in[7:0] = 8'h3C;
        repeat (3) cyc();
        rd(8'h90, d, cs);
        n_cmp++; if (d !== 8'h35) begin n_err++; $display("FAIL mixed_readback got %h want 35", d); end
    endtask

    task automatic test_edge_irq();
        logic [7:0] d; logic cs;
        wr(8'h95, 8'h00, 1);
        wr(8'h96, 8'h01, 1);
        pin_in[8] = 1'b1;
        cyc(); cyc();
        rd(8'h97, d, cs);
        n_cmp++; if (d !== 8'h00 || bus.n_int !== 1'b1) begin n_err++; $display("FAIL irq_early got istat=%h n_int=%b want 00/1", d, bus.n_int); end
        cyc();
        rd(8'h97, d, cs);
        n_cmp++; if (d !== 8'h01 || bus.n_int !== 1'b0) begin n_err++; $display("FAIL irq_set got istat=%h n_int=%b want 01/0", d, bus.n_int); end
        wr(8'h97, 8'h01, 1);
        rd(8'h97, d, cs);
        n_cmp++; if (d !== 8'h00 || bus.n_int !== 1'b1) begin n_err++; $display("FAIL w1c_clear got istat=%h n_int=%b want 00/1", d, bus.n_int); end
        pin_in[8] = 1'b0;
        repeat (5) cyc();
        rd(8'h97, d, cs);
        n_cmp++; if (d !== 8'h00 || bus.n_int !== 1'b1) begin n_err++; $display("FAIL falling_edge got istat=%h n_int=%b want 00/1", d, bus.n_int); end
    endtask

    task automatic test_w1c_collision();
        logic [7:0] d; logic cs;
        pin_in[8] = 1'b1;
        cyc(); cyc();
        bus.addr = 8'h97; bus.dataIn = 8'h01; bus.n_wr = 1'b0;
        cyc();
        bus.n_wr = 1'b1;
        cyc();
        rd(8'h97, d, cs);
        n_cmp++; if (d !== 8'h01 || bus.n_int !== 1'b0) begin n_err++; $display("FAIL collision got istat=%h n_int=%b want 01/0", d, bus.n_int); end
        wr(8'h97, 8'h01, 2);
        rd(8'h97, d, cs);
        n_cmp++; if (d !== 8'h00 || bus.n_int !== 1'b1) begin n_err++; $display("FAIL post_collision_clear got istat=%h n_int=%b want 00/1", d, bus.n_int); end
    endtask

    task automatic test_random();
        logic [7:0] d; logic cs;
        int p;
        repeat (4) cyc();
        for (int q = 0; q < 2; q++) m_last[q] = pin_in[8*q +: 8];
        wr(8'h93, 8'hFF, 1);
        wr(8'h97, 8'hFF, 1);
        m_istat[0] = 0; m_istat[1] = 0;
        for (int q = 0; q < 2; q++) begin
            wr(8'(8'h90 + 4*q), 8'($urandom), 1);
            wr(8'(8'h91 + 4*q), 8'($urandom), 1);
            wr(8'(8'h92 + 4*q), 8'($urandom), 1);
        end
        for (int it = 0; it < 30; it++) begin
            p = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                1: wr(8'(8'h93 + 4*p), 8'($urandom), int'($urandom_range(1, 3)));
                2: wr(8'(8'h91 + 4*p), 8'($urandom), int'($urandom_range(1, 3)));
                default: begin
                    set_pins(16'($urandom));
                    repeat (4) cyc();
                end
            endcase
            for (int q = 0; q < 2; q++) begin
                rd(8'(8'h90 + 4*q), d, cs);
                n_cmp++; if (d !== ((m_data[q] & m_dir[q]) | (m_last[q] & ~m_dir[q]))) begin
                    n_err++; $display("FAIL rand_data it=%0d p=%0d got %h want %h", it, q,
                                      d, (m_data[q] & m_dir[q]) | (m_last[q] & ~m_dir[q]));
                end
                rd(8'(8'h93 + 4*q), d, cs);
                n_cmp++; if (d !== m_istat[q]) begin n_err++; $display("FAIL rand_istat it=%0d p=%0d got %h want %h", it, q, d, m_istat[q]); end
            end
            n_cmp++; if (pin_out !== {m_data[1], m_data[0]} || pin_oe !== {m_dir[1], m_dir[0]}) begin
                n_err++; $display("FAIL rand_pins it=%0d got out=%h oe=%h want out=%h oe=%h", it, pin_out, pin_oe,
                                  {m_data[1], m_data[0]}, {m_dir[1], m_dir[0]});
            end
            n_cmp++; if (bus.n_int !== exp_n_int()) begin n_err++; $display("FAIL rand_n_int it=%0d got %b want %b", it, bus.n_int, exp_n_int()); end
        end
    endtask

    task automatic test_reset_wr_low();
        logic [7:0] d; logic cs;
        int c0;
        c0 = wr_cnt;
        pin_in = 16'h0001;
        bus.addr = 8'h90; bus.dataIn = 8'h5A; bus.n_wr = 1'b0; n_reset = 1'b1;
        repeat (2) cyc();
        model_reset();
        n_reset = 1'b0;
        repeat (4) cyc();
        n_cmp++; if (pin_out !== 16'h0000 || pin_oe !== 16'h0000) begin n_err++; $display("FAIL reset_wr_low_pins got out=%h oe=%h want 0000/0000", pin_out, pin_oe); end
        n_cmp++; if (wr_cnt - c0 !== 0) begin n_err++; $display("FAIL reset_wr_low_count got %0d want 0", wr_cnt - c0); end
        bus.n_wr = 1'b1;
        cyc();
        rd(8'h90, d, cs);
        n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL reset_wr_low_data got %h want 01", d); end
        rd(8'h93, d, cs);
        n_cmp++; if (d !== 8'h01 || bus.n_int !== 1'b1) begin n_err++; $display("FAIL reset_high_pin got istat=%h n_int=%b want 01/1", d, bus.n_int); end
        wr(8'h92, 8'h01, 1);
        n_cmp++; if (bus.n_int !== 1'b0) begin n_err++; $display("FAIL late_mask_n_int got %b want 0", bus.n_int); end
    endtask

    initial begin
        test_reset();
        test_long_strobe();
        test_mixed_readback();
        test_edge_irq();
        test_w1c_collision();
        test_random();
        test_reset_wr_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
